// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - store-path aligner with exception flagging and DEPTH-entry FIFO
//
// Purpose:
//   Turns a store request (byte address, size, right-justified register data)
//   into lane-aligned write data plus byte strobes. Misaligned stores and
//   illegal sizes are accepted but dropped, raising a one-cycle exc_ades pulse.
//   Legal stores are queued in a DEPTH-entry FIFO towards the cache/AXI write port.
//
// Configuration macro:
//   STORE_ALIGN_BYPASS_EN - when defined, an empty FIFO with a ready consumer
//   forwards a legal request combinationally to out_* without enqueueing it.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   in_valid/in_ready        request handshake (in_ready = ~full)
//   in_addr, in_size         byte address, log2 of store size in bytes
//   in_data                  store data, right-justified
//   out_valid/out_ready      head-entry handshake
//   out_addr                 in_addr with lane offset bits cleared
//   out_data, out_strb       lane-aligned data and byte enables
//   exc_ades                 one-cycle pulse when a bad request was dropped
//   exc_badvaddr             address of the latest dropped request
//   count, empty             FIFO occupancy

module store_align_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [1:0]                 in_size,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [DATA_W/8-1:0]        out_strb,
    output logic                       exc_ades,
    output logic [ADDR_W-1:0]          exc_badvaddr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);

    // ------------------------------------------------------------------
    // Alignment datapath
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]  off;
    logic [OFF_W-1:0]  align_mask;
    logic [NBYTES-1:0] raw_strb;
    logic [DATA_W-1:0] masked_data;
    logic              size_ok;
    logic              legal;
    logic [ADDR_W-1:0] al_addr;
    logic [DATA_W-1:0] al_data;
    logic [NBYTES-1:0] al_strb;

    assign off = in_addr[OFF_W-1:0];

    always_comb begin
        align_mask = '0;
        raw_strb   = '0;
        case (in_size)
            2'd0: begin align_mask = '0;          raw_strb = NBYTES'(8'h01); end
            2'd1: begin align_mask = OFF_W'(1);   raw_strb = NBYTES'(8'h03); end
            2'd2: begin align_mask = OFF_W'(3);   raw_strb = NBYTES'(8'h0F); end
            default: begin align_mask = OFF_W'(7); raw_strb = NBYTES'(8'hFF); end
        endcase
    end

    // Doubleword stores only exist on the 64-bit datapath.
    assign size_ok = (in_size != 2'd3) || (DATA_W == 64);
    assign legal   = size_ok && ((off & align_mask) == '0);

    always_comb begin
        masked_data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            masked_data[8*i +: 8] = raw_strb[i] ? in_data[8*i +: 8] : 8'h00;
        end
    end

    assign al_data = masked_data << {off, 3'b000};
    assign al_strb = raw_strb << off;
    assign al_addr = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [NBYTES-1:0] mem_strb [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              head_valid;
    logic              accept;
    logic              bypass;
    logic              push;
    logic              pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_valid = ~empty;
    assign in_ready   = ~full;
    assign accept     = in_valid & in_ready;

`ifdef STORE_ALIGN_BYPASS_EN
    assign bypass = empty & in_valid & legal & out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed request is consumed directly and never touches storage.
    assign push = accept & legal & ~bypass;
    assign pop  = head_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; outputs are gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= al_addr;
            mem_data[wr_ptr] <= al_data;
            mem_strb[wr_ptr] <= al_strb;
        end
    end

    always_comb begin
        out_valid = head_valid;
        out_addr  = head_valid ? mem_addr[rd_ptr] : '0;
        out_data  = head_valid ? mem_data[rd_ptr] : '0;
        out_strb  = head_valid ? mem_strb[rd_ptr] : '0;
        if (bypass) begin
            out_valid = 1'b1;
            out_addr  = al_addr;
            out_data  = al_data;
            out_strb  = al_strb;
        end
    end

    // ------------------------------------------------------------------
    // Address-error exception
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_ades     <= 1'b0;
            exc_badvaddr <= '0;
        end else begin
            exc_ades <= accept & ~legal;
            if (accept && !legal) exc_badvaddr <= in_addr;
        end
    end

endmodule
